// File: rtl/uart_imem_loader.sv
// Boot loader: packs UART bytes little-endian into 32-bit words and writes them to instruction memory.
// Optional inter-byte timeout is enabled by defining INTER_BYTE_TIMEOUT_EN.
module uart_imem_loader #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DEPTH          = 256,
  parameter logic [31:0] END_WORD       = 32'hFFFF_FFFF,
  parameter int unsigned TIMEOUT_CYCLES = 500_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx_valid,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_break,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              write_done,
  output logic [ADDR_W:0]   words_loaded,
  output logic              load_error
);

  typedef enum logic [1:0] {LOAD, WRITE, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  state_t          state;
  logic [1:0]      byte_idx;
  logic [31:0]     asm_word;
  logic [31:0]     full_word;
  logic [ADDR_W:0] words_next;
  logic            gap_hit;

  assign full_word  = {uart_rx_data, asm_word[23:0]};
  assign words_next = words_loaded + (ADDR_W+1)'(1);

`ifdef INTER_BYTE_TIMEOUT_EN
  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [GAP_W-1:0] gap_cnt;

  // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle with a partial word pending.
  assign gap_hit = (state == LOAD) && (byte_idx != 2'd0) && !uart_rx_valid && !uart_rx_break &&
                   (gap_cnt == GAP_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt <= '0;
    end else if (uart_rx_valid || byte_idx == 2'd0 || state != LOAD || gap_hit) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_cnt + GAP_W'(1);
    end
  end
`else
  logic unused_timeout;

  assign gap_hit        = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= LOAD;
      byte_idx     <= '0;
      asm_word     <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      write_done   <= 1'b0;
      words_loaded <= '0;
      load_error   <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (uart_rx_break) begin
            if (byte_idx != 2'd0) load_error <= 1'b1;
            byte_idx   <= '0;
            write_done <= 1'b1;
            state      <= DONE;
          end else if (uart_rx_valid) begin
            asm_word[8*byte_idx +: 8] <= uart_rx_data;
            byte_idx                  <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              if (full_word == END_WORD) begin
                write_done <= 1'b1;
                state      <= DONE;
              end else begin
                imem_we    <= 1'b1;
                imem_wdata <= full_word;
                imem_addr  <= words_loaded[ADDR_W-1:0];
                state      <= WRITE;
              end
            end
          end else if (gap_hit) begin
            byte_idx   <= '0;
            load_error <= 1'b1;
          end
        end
        WRITE: begin
          // The write in flight always completes; only the follow-on state depends on BREAK/full.
          imem_we      <= 1'b0;
          words_loaded <= words_next;
          if (uart_rx_break) begin
            if (byte_idx != 2'd0) load_error <= 1'b1;
            byte_idx   <= '0;
            write_done <= 1'b1;
            state      <= DONE;
          end else if (words_next == DEPTH_CNT) begin
            write_done <= 1'b1;
            state      <= DONE;
          end else begin
            if (uart_rx_valid) begin
              asm_word[8*byte_idx +: 8] <= uart_rx_data;
              byte_idx                  <= byte_idx + 2'd1;
            end
            state <= LOAD;
          end
        end
        DONE: begin
          imem_we    <= 1'b0;
          write_done <= 1'b1;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed self-checking bench for uart_imem_loader (default-depth and DEPTH=4 instances).
module tb_uart_imem_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx_valid = 1'b0;
  logic [7:0] uart_rx_data = '0;
  logic       uart_rx_break = 1'b0;

  logic       imem_we, write_done, load_error;
  logic [7:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0] words_loaded;

  logic       we4, done4, err4;
  logic [7:0] addr4;
  logic [31:0] wdata4;
  logic [8:0] wl4;

  int errors = 0;
  int checks = 0;

  logic [7:0]  wa[$];
  logic [31:0] wd[$];
  logic [7:0]  wa4[$];
  logic [31:0] wd4[$];

  always #5 clk = ~clk;

  uart_imem_loader #(.ADDR_W(8), .DEPTH(256), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
    .uart_rx_break(uart_rx_break), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .write_done(write_done), .words_loaded(words_loaded),
    .load_error(load_error));

  uart_imem_loader #(.ADDR_W(8), .DEPTH(4), .TIMEOUT_CYCLES(100)) dut4 (
    .clk(clk), .rst(rst), .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
    .uart_rx_break(uart_rx_break), .imem_we(we4), .imem_addr(addr4),
    .imem_wdata(wdata4), .write_done(done4), .words_loaded(wl4),
    .load_error(err4));

  always @(posedge clk) begin
    if (imem_we) begin wa.push_back(imem_addr); wd.push_back(imem_wdata); end
    if (we4)     begin wa4.push_back(addr4);    wd4.push_back(wdata4);     end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; uart_rx_valid = 1'b0; uart_rx_break = 1'b0; uart_rx_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wa.delete(); wd.delete(); wa4.delete(); wd4.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    uart_rx_valid = 1'b1; uart_rx_data = b;
    @(negedge clk);
    uart_rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (imem_we !== 1'b0)      begin errors++; $display("FAIL reset_we: got %b want 0", imem_we); end
    checks++; if (imem_addr !== 8'h00)   begin errors++; $display("FAIL reset_addr: got %h want 00", imem_addr); end
    checks++; if (imem_wdata !== 32'h0)  begin errors++; $display("FAIL reset_wdata: got %h want 0", imem_wdata); end
    checks++; if (write_done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b want 0", write_done); end
    checks++; if (words_loaded !== 9'd0) begin errors++; $display("FAIL reset_words: got %0d want 0", words_loaded); end
    checks++; if (load_error !== 1'b0)   begin errors++; $display("FAIL reset_err: got %b want 0", load_error); end
  endtask

  task automatic test_single_word();
    do_reset();
    send_byte(8'h13, 1); send_byte(8'h05, 1); send_byte(8'h00, 1);
    @(negedge clk); uart_rx_valid = 1'b1; uart_rx_data = 8'h00;
    @(negedge clk); uart_rx_valid = 1'b0;
    checks++; if (imem_we !== 1'b1) begin errors++; $display("FAIL latency_we: got %b want 1", imem_we); end
    repeat (3) @(negedge clk);
    checks++; if (wa.size() !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", wa.size()); end
    if (wa.size() == 1) begin
      checks++; if (wa[0] !== 8'h00)         begin errors++; $display("FAIL single_addr: got %h want 00", wa[0]); end
      checks++; if (wd[0] !== 32'h0000_0513) begin errors++; $display("FAIL single_data: got %h want 00000513", wd[0]); end
    end
    checks++; if (words_loaded !== 9'd1)  begin errors++; $display("FAIL single_words: got %0d want 1", words_loaded); end
    checks++; if (imem_wdata !== 32'h0000_0513) begin errors++; $display("FAIL single_hold: got %h want 00000513", imem_wdata); end
    checks++; if (write_done !== 1'b0)    begin errors++; $display("FAIL single_done: got %b want 0", write_done); end
  endtask

  task automatic test_terminator();
    do_reset();
    send_word(32'h0000_0513); send_word(32'h0010_0093); send_word(32'hFFFF_FFFF);
    send_word(32'h1234_5678);
    repeat (3) @(negedge clk);
    checks++; if (wa.size() !== 2) begin errors++; $display("FAIL term_count: got %0d want 2", wa.size()); end
    if (wa.size() == 2) begin
      checks++; if (wa[1] !== 8'h01)         begin errors++; $display("FAIL term_addr1: got %h want 01", wa[1]); end
      checks++; if (wd[1] !== 32'h0010_0093) begin errors++; $display("FAIL term_data1: got %h want 00100093", wd[1]); end
    end
    checks++; if (write_done !== 1'b1)    begin errors++; $display("FAIL term_done: got %b want 1", write_done); end
    checks++; if (words_loaded !== 9'd2)  begin errors++; $display("FAIL term_words: got %0d want 2", words_loaded); end
    checks++; if (load_error !== 1'b0)    begin errors++; $display("FAIL term_err: got %b want 0", load_error); end
  endtask

  task automatic test_depth();
    logic [31:0] w;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      w = {4{8'(i + 1)}};
      send_word(w);
    end
    repeat (3) @(negedge clk);
    checks++; if (wa4.size() !== 4) begin errors++; $display("FAIL depth_count: got %0d want 4", wa4.size()); end
    for (int i = 0; i < 4 && i < wa4.size(); i++) begin
      w = {4{8'(i + 1)}};
      checks++; if (wa4[i] !== 8'(i)) begin errors++; $display("FAIL depth_addr%0d: got %h want %h", i, wa4[i], 8'(i)); end
      checks++; if (wd4[i] !== w)     begin errors++; $display("FAIL depth_data%0d: got %h want %h", i, wd4[i], w); end
    end
    checks++; if (done4 !== 1'b1) begin errors++; $display("FAIL depth_done: got %b want 1", done4); end
    checks++; if (wl4 !== 9'd4)   begin errors++; $display("FAIL depth_words: got %0d want 4", wl4); end
  endtask

  task automatic test_break();
    do_reset();
    send_byte(8'h13, 1); send_byte(8'h05, 1);
    @(negedge clk); uart_rx_break = 1'b1; uart_rx_valid = 1'b1; uart_rx_data = 8'h00;
    @(negedge clk); uart_rx_break = 1'b0; uart_rx_valid = 1'b0;
    send_word(32'h0000_0513);
    repeat (3) @(negedge clk);
    checks++; if (wa.size() !== 0)     begin errors++; $display("FAIL break_count: got %0d want 0", wa.size()); end
    checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL break_err: got %b want 1", load_error); end
    checks++; if (write_done !== 1'b1) begin errors++; $display("FAIL break_done: got %b want 1", write_done); end
  endtask

  task automatic test_break_in_write();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); uart_rx_valid = 1'b1; uart_rx_data = 8'h41 + 8'(i);
    end
    @(negedge clk); uart_rx_valid = 1'b0; uart_rx_break = 1'b1;
    @(negedge clk); uart_rx_break = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (wa.size() !== 1)       begin errors++; $display("FAIL bw_count: got %0d want 1", wa.size()); end
    if (wa.size() == 1) begin
      checks++; if (wd[0] !== 32'h4443_4241) begin errors++; $display("FAIL bw_data: got %h want 44434241", wd[0]); end
    end
    checks++; if (load_error !== 1'b0)   begin errors++; $display("FAIL bw_err: got %b want 0", load_error); end
    checks++; if (write_done !== 1'b1)   begin errors++; $display("FAIL bw_done: got %b want 1", write_done); end
    checks++; if (words_loaded !== 9'd1) begin errors++; $display("FAIL bw_words: got %0d want 1", words_loaded); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] stream;
    do_reset();
    stream = 64'h0010_0093_0000_0513;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); uart_rx_valid = 1'b1; uart_rx_data = stream[8*i +: 8];
    end
    @(negedge clk); uart_rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (wa.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", wa.size()); end
    if (wa.size() == 2) begin
      checks++; if (wd[0] !== 32'h0000_0513) begin errors++; $display("FAIL b2b_data0: got %h want 00000513", wd[0]); end
      checks++; if (wd[1] !== 32'h0010_0093) begin errors++; $display("FAIL b2b_data1: got %h want 00100093", wd[1]); end
      checks++; if (wa[1] !== 8'h01)         begin errors++; $display("FAIL b2b_addr1: got %h want 01", wa[1]); end
    end
    checks++; if (words_loaded !== 9'd2) begin errors++; $display("FAIL b2b_words: got %0d want 2", words_loaded); end
  endtask

  task automatic test_reset_midload();
    do_reset();
    send_byte(8'h77, 1); send_byte(8'h66, 1);
    do_reset();
    send_word(32'h0000_0513);
    repeat (3) @(negedge clk);
    checks++; if (wa.size() !== 1) begin errors++; $display("FAIL rml_count: got %0d want 1", wa.size()); end
    if (wa.size() == 1) begin
      checks++; if (wa[0] !== 8'h00)         begin errors++; $display("FAIL rml_addr: got %h want 00", wa[0]); end
      checks++; if (wd[0] !== 32'h0000_0513) begin errors++; $display("FAIL rml_data: got %h want 00000513", wd[0]); end
    end
    checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL rml_err: got %b want 0", load_error); end
  endtask

`ifdef INTER_BYTE_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    send_byte(8'h11, 120);
    send_word(32'hDDCC_BBAA);
    repeat (3) @(negedge clk);
    checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", load_error); end
    checks++; if (wa.size() !== 1)     begin errors++; $display("FAIL to_count: got %0d want 1", wa.size()); end
    if (wa.size() == 1) begin
      checks++; if (wa[0] !== 8'h00)         begin errors++; $display("FAIL to_addr: got %h want 00", wa[0]); end
      checks++; if (wd[0] !== 32'hDDCC_BBAA) begin errors++; $display("FAIL to_data: got %h want ddccbbaa", wd[0]); end
    end
    checks++; if (write_done !== 1'b0) begin errors++; $display("FAIL to_done: got %b want 0", write_done); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_terminator();
    test_depth();
    test_break();
    test_break_in_write();
    test_back_to_back();
    test_reset_midload();
`ifdef INTER_BYTE_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
